muldiv_unit: RTL
================

# muldiv_unit

Iterative multiply/divide unit implementing the RV32M operations for the execute stage, generalised over WORD_SIZE. It accepts one operation per start pulse, computes a restoring shift-add/shift-subtract sequence at one bit per cycle, and returns a registered result with a one-cycle done pulse. The hazard logic holds the ID/EX and earlier pipeline registers while busy is high. A pipeline flush can abort an operation in progress.

## Interface
- WORD_SIZE, 32: operand and result width; even, >= 4.
- CNT_SIZE, $clog2(WORD_SIZE+1): iteration counter width.

- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  abort the current operation and return to IDLE.
- start  in  1  request; sampled only in IDLE.
- op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  in  WORD_SIZE  rs1 operand; sampled with start.
- b  in  WORD_SIZE  rs2 operand; sampled with start.
- busy  out  1  high in RUN; feeds the stall request.
- done  out  1  one-cycle pulse; result is valid.
- result  out  WORD_SIZE  registered result; held until the next done.

## Operation
- **States:** IDLE, RUN, DONE (2-bit encoding).
- **IDLE:**
  - start=1 latches op, the operand signs, the operand magnitudes and the counter.
  - Signed ops use two's-complement magnitude: MULH treats a and b as signed; MULHSU treats only a as signed; DIV and REM treat both as signed.
  - Next state is RUN, or DONE on the fast path.
- **Fast path (divide ops only):**
  - b==0: quotient = all ones, remainder = a.
  - Signed overflow (a = 1 followed by zeros, b = all ones, DIV or REM): quotient = a, remainder = 0.
  - The result is registered at the start edge and the next state is DONE.
- **RUN, multiply:**
  - 2W-bit accumulator. Each cycle, if the multiplier LSB is 1, add the multiplicand into the upper half.
  - Then shift the accumulator and multiplier right by 1.
- **RUN, divide:**
  - Restoring division. Each cycle, shift {remainder, quotient} left by 1 and trial-subtract the divisor from the remainder.
  - On no borrow, keep the difference and set quotient LSB = 1.
- **RUN counter and exit:**
  - The counter decrements from WORD_SIZE.
  - When it reaches 1, apply the sign fix, register result, and go to DONE.
- **Sign fix:**
  - Product is negated if the sign flags differ.
  - Quotient is negated if sa^sb.
  - Remainder is negated if sa.
- **Result selection:**
  - MUL takes the low W bits.
  - MULH, MULHSU and MULHU take the high W bits.
  - DIV and DIVU take the quotient; REM and REMU take the remainder.
- **DONE:** done=1 for exactly one cycle, then IDLE. start in DONE is ignored; the pipeline reissues it.
- **start while busy:** ignored; operands are not re-sampled.
- **flush:**
  - In any state, the next state is IDLE. busy falls and done is not asserted.
  - result keeps its previous value.
  - flush and start in the same IDLE cycle: flush wins and nothing is accepted.
- **rst:** overrides flush and start. State = IDLE, busy = 0, done = 0, result = 0, all datapath registers = 0.

## Timing
- Let E0 be the edge that samples start in IDLE.
- **Normal latency:**
  - busy is high after E0 through E_WORD_SIZE.
  - done is high for the cycle following edge E_(WORD_SIZE+1); for WORD_SIZE = 32, that is 33 edges after E0.
  - result changes at the edge that raises done.
- **Fast-path latency:** done is high after E1. busy is never asserted.
- Back-to-back issue: IDLE re-entered after the done cycle, so the minimum start-to-start spacing is WORD_SIZE+2 cycles (normal) or 2 cycles (fast path).
- No combinational path exists from start, a or b to any output; all outputs are registered.

## Test plan
- **Reset mid-RUN:** rst asserted at cycle 10 of a DIVU -> next cycle busy=0, done=0, result=0. A new MUL 3*5 then gives result=15.
- **Multiply family (W=32):**
  - MUL 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001.
  - MULHU of the same operands -> 0xFFFFFFFE.
  - MULH -> 0x00000000.
  - MULHSU -> 0xFFFFFFFF.
  - Each with done exactly 33 cycles after start.
- **Signed divide:**
  - DIV -7/2 -> 0xFFFFFFFD.
  - REM -7/2 -> 0xFFFFFFFF.
  - DIVU 100/7 -> 14.
  - REMU 100/7 -> 2.
- **Fast paths:**
  - DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
  - Each with done 1 cycle after start and busy never high.
- **Flush and ignored start:**
  - flush at RUN cycle 5 -> IDLE next cycle, no done pulse, result unchanged.
  - start asserted during RUN with different operands -> original result returned.
- **Parameter sweep:** WORD_SIZE=8 with random operands checked against a reference model -> all 8 ops match; done at 9 cycles.

Source files
------------

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RV32M multiply/divide unit for the execute stage,
//               generalised over WORD_SIZE. One bit per cycle: shift-add for
//               multiply, restoring shift-subtract for divide. Divide-by-zero
//               and signed overflow take a single-cycle fast path.
// Ports       : clk    - clock, rising edge
//               rst    - synchronous active-high reset
//               flush  - abort current operation, return to idle
//               start  - operation request, sampled only when idle
//               op     - funct3 (MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU)
//               a, b   - rs1 / rs2 operands, sampled with start
//               busy   - high while iterating (stall request)
//               done   - one-cycle pulse, result valid
//               result - registered result, held until the next done
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int WORD_SIZE = 32,
    parameter int CNT_SIZE  = $clog2(WORD_SIZE + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 start,
    input  logic [2:0]           op,
    input  logic [WORD_SIZE-1:0] a,
    input  logic [WORD_SIZE-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [WORD_SIZE-1:0] result
);

    // State encoding
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    // funct3 encodings
    localparam logic [2:0] c_op_mul    = 3'b000;
    localparam logic [2:0] c_op_mulh   = 3'b001;
    localparam logic [2:0] c_op_mulhsu = 3'b010;
    localparam logic [2:0] c_op_mulhu  = 3'b011;
    localparam logic [2:0] c_op_div    = 3'b100;
    localparam logic [2:0] c_op_divu   = 3'b101;
    localparam logic [2:0] c_op_rem    = 3'b110;
    localparam logic [2:0] c_op_remu   = 3'b111;

    localparam logic [CNT_SIZE-1:0]  c_cnt_init = CNT_SIZE'(WORD_SIZE);
    localparam logic [CNT_SIZE-1:0]  c_cnt_last = CNT_SIZE'(1);
    localparam logic [WORD_SIZE-1:0] c_min_neg  = {1'b1, {(WORD_SIZE-1){1'b0}}};

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;

    logic [2:0]           r_op;
    logic                 r_sa;
    logic                 r_sb;
    // r_hi: product high half / partial remainder
    // r_lo: multiplier being shifted out / dividend becoming quotient
    // r_b : multiplicand / divisor magnitude
    logic [WORD_SIZE-1:0] r_hi;
    logic [WORD_SIZE-1:0] r_lo;
    logic [WORD_SIZE-1:0] r_b;
    logic [CNT_SIZE-1:0]  r_cnt;
    logic [WORD_SIZE-1:0] r_res;
    logic                 r_done;
    logic [WORD_SIZE-1:0] r_result;

    // Operand decode
    logic                 w_a_signed;
    logic                 w_b_signed;
    logic                 w_sa_in;
    logic                 w_sb_in;
    logic [WORD_SIZE-1:0] w_a_mag;
    logic [WORD_SIZE-1:0] w_b_mag;
    logic                 w_is_div;
    logic                 w_div0;
    logic                 w_ovf;
    logic                 w_fast;
    logic [WORD_SIZE-1:0] w_fast_res;

    // Iteration datapath
    logic [WORD_SIZE:0]   w_sum;
    logic [WORD_SIZE:0]   w_rem_sh;
    logic                 w_ge;
    logic [WORD_SIZE-1:0] w_rem_dif;
    logic [WORD_SIZE-1:0] w_hi_nxt;
    logic [WORD_SIZE-1:0] w_lo_nxt;

    // Sign fix and result select
    logic [2*WORD_SIZE-1:0] w_prod;
    logic [2*WORD_SIZE-1:0] w_prod_fix;
    logic [WORD_SIZE-1:0]   w_quo_fix;
    logic [WORD_SIZE-1:0]   w_rem_fix;
    logic [WORD_SIZE-1:0]   w_final;

    assign busy   = (r_state == c_st_run);
    assign done   = r_done;
    assign result = r_result;

    // ------------------------------------------------------------------
    // Operand decode (only meaningful in idle when start is sampled)
    // ------------------------------------------------------------------
    always_comb begin
        w_a_signed = (op == c_op_mulh) || (op == c_op_mulhsu) ||
                     (op == c_op_div)  || (op == c_op_rem);
        w_b_signed = (op == c_op_mulh) || (op == c_op_div) || (op == c_op_rem);
        w_sa_in    = w_a_signed & a[WORD_SIZE-1];
        w_sb_in    = w_b_signed & b[WORD_SIZE-1];
        w_a_mag    = w_sa_in ? -a : a;
        w_b_mag    = w_sb_in ? -b : b;
        w_is_div   = op[2];
        w_div0     = (b == '0);
        w_ovf      = ((op == c_op_div) || (op == c_op_rem)) &&
                     (a == c_min_neg) && (b == '1);
        w_fast     = w_is_div && (w_div0 || w_ovf);
        // op[1] distinguishes REM/REMU from DIV/DIVU
        if (w_div0) begin
            w_fast_res = op[1] ? a : '1;
        end else begin
            w_fast_res = op[1] ? '0 : a;
        end
    end

    // ------------------------------------------------------------------
    // One iteration step, selected by the latched operation class
    // ------------------------------------------------------------------
    always_comb begin
        // Multiply: add multiplicand to the upper half when the multiplier
        // LSB is set, then shift the whole {carry, hi, lo} right by one.
        w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(WORD_SIZE+1){1'b0}});

        // Divide: shift {rem, quo} left; the shifted remainder can need one
        // extra bit before the trial subtraction brings it back below r_b.
        w_rem_sh  = {r_hi, r_lo[WORD_SIZE-1]};
        w_ge      = (w_rem_sh >= {1'b0, r_b});
        w_rem_dif = w_rem_sh[WORD_SIZE-1:0] - r_b;

        if (r_op[2]) begin
            w_hi_nxt = w_ge ? w_rem_dif : w_rem_sh[WORD_SIZE-1:0];
            w_lo_nxt = {r_lo[WORD_SIZE-2:0], w_ge};
        end else begin
            w_hi_nxt = w_sum[WORD_SIZE:1];
            w_lo_nxt = {w_sum[0], r_lo[WORD_SIZE-1:1]};
        end
    end

    // ------------------------------------------------------------------
    // Sign fix applied to the values produced by the final iteration
    // ------------------------------------------------------------------
    always_comb begin
        w_prod     = {w_hi_nxt, w_lo_nxt};
        w_prod_fix = (r_sa ^ r_sb) ? -w_prod : w_prod;
        w_quo_fix  = (r_sa ^ r_sb) ? -w_lo_nxt : w_lo_nxt;
        w_rem_fix  = r_sa ? -w_hi_nxt : w_hi_nxt;
        w_final    = '0;
        case (r_op)
            c_op_mul:                          w_final = w_prod_fix[WORD_SIZE-1:0];
            c_op_mulh, c_op_mulhsu, c_op_mulhu: w_final = w_prod_fix[2*WORD_SIZE-1:WORD_SIZE];
            c_op_div, c_op_divu:               w_final = w_quo_fix;
            c_op_rem, c_op_remu:               w_final = w_rem_fix;
            default:                           w_final = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM next-state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (start) begin
                    w_state_nxt = w_fast ? c_st_done : c_st_run;
                end
            end
            c_st_run: begin
                if (r_cnt == c_cnt_last) begin
                    w_state_nxt = c_st_done;
                end
            end
            c_st_done: w_state_nxt = c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
        if (flush) begin
            w_state_nxt = c_st_idle;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= '0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_res    <= '0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            // The output stage publishes r_res on the edge that leaves DONE,
            // so done and result change together and a flush in DONE
            // suppresses both.
            r_done <= (r_state == c_st_done) && !flush;
            if ((r_state == c_st_done) && !flush) begin
                r_result <= r_res;
            end

            case (r_state)
                c_st_idle: begin
                    if (start && !flush) begin
                        r_op  <= op;
                        r_sa  <= w_sa_in;
                        r_sb  <= w_sb_in;
                        r_hi  <= '0;
                        r_cnt <= c_cnt_init;
                        // Multiply keeps the multiplier in r_lo; divide keeps
                        // the dividend there so it shifts into the remainder.
                        r_lo  <= w_is_div ? w_a_mag : w_b_mag;
                        r_b   <= w_is_div ? w_b_mag : w_a_mag;
                        if (w_fast) begin
                            r_res <= w_fast_res;
                        end
                    end
                end
                c_st_run: begin
                    if (!flush) begin
                        r_hi  <= w_hi_nxt;
                        r_lo  <= w_lo_nxt;
                        r_cnt <= r_cnt - c_cnt_last;
                        if (r_cnt == c_cnt_last) begin
                            r_res <= w_final;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
